// File: rtl/alarm_snooze_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_snooze_ctrl
//
// Decides when the alarm buzzer sounds. Takes the live time and the alarm
// setting registers and adds snooze, dismiss, ring timeout and a snooze limit
// on top of the raw alarm match. Clocked by the 1 Hz pulse that drives the
// time counters, so one clk cycle is one second.
//
// Ports:
//   clk       in   1  1 Hz pulse clock
//   rst       in   1  synchronous, active-high reset
//   tsec      in   7  current seconds 0..59
//   tmin      in   7  current minutes 0..59
//   thrs      in   7  current hours 0..23
//   tdays     in   7  current day 0..ND-1
//   amin      in   7  alarm minutes
//   ahrs      in   7  alarm hours
//   adays     in   7  alarm day 0..ND (ND = every day)
//   alarmon   in   1  alarm armed
//   snooze    in   1  snooze button level
//   dismiss   in   1  dismiss button level
//   buzz      out  1  buzzer drive (registered, high while ringing)
//   snoozing  out  1  high while snoozing (registered)
//   snz_cnt   out  4  snoozes used in the current alarm event
// ---------------------------------------------------------------------------
module alarm_snooze_ctrl #(
  parameter int unsigned SNOOZE_S = 540,
  parameter int unsigned RING_S   = 60,
  parameter int unsigned MAX_SNZ  = 3,
  parameter int unsigned ND       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] tsec,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic [6:0] tdays,
  input  logic [6:0] amin,
  input  logic [6:0] ahrs,
  input  logic [6:0] adays,
  input  logic       alarmon,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzz,
  output logic       snoozing,
  output logic [3:0] snz_cnt
);

  // Timer widths; kept at least one bit wide so degenerate parameters still elaborate.
  localparam int unsigned SW = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;
  localparam int unsigned RW = (RING_S > 1) ? $clog2(RING_S) : 1;

  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_S - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_S - 1);
  localparam logic [3:0]    SNZ_MAX   = 4'(MAX_SNZ);
  localparam logic [6:0]    DAILY     = 7'(ND);

  typedef enum logic [1:0] {
    StIdle,
    StRing,
    StSnooze
  } state_e;

  state_e          r_state;
  logic [RW-1:0]   r_ring_tmr;
  logic [SW-1:0]   r_snz_tmr;
  logic [3:0]      r_snz_cnt;
  logic            r_buzz;
  logic            r_snoozing;

  logic w_day_ok;
  logic w_match;
  logic w_ring_end;
  logic w_snz_end;
  logic w_limit;

  // Requiring tsec == 0 makes the match a single-cycle event per matching minute.
  assign w_day_ok   = (adays == DAILY) || (tdays == adays);
  assign w_match    = alarmon && (tsec == 7'd0) && (tmin == amin) && (thrs == ahrs) && w_day_ok;

  // Ring stretch ends on a snooze press or after RING_S buzzing cycles.
  assign w_ring_end = snooze || (r_ring_tmr == RING_LAST);
  assign w_snz_end  = (r_snz_tmr == '0);
  assign w_limit    = (r_snz_cnt == SNZ_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_ring_tmr <= '0;
      r_snz_tmr  <= '0;
      r_snz_cnt  <= '0;
      r_buzz     <= 1'b0;
      r_snoozing <= 1'b0;
    end else if (!alarmon) begin
      // Disarming aborts any event, whatever the state.
      r_state    <= StIdle;
      r_ring_tmr <= '0;
      r_snz_tmr  <= '0;
      r_snz_cnt  <= '0;
      r_buzz     <= 1'b0;
      r_snoozing <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ring_tmr <= '0;
          r_snz_tmr  <= '0;
          r_snz_cnt  <= '0;
          r_snoozing <= 1'b0;
          if (w_match) begin
            r_state <= StRing;
            r_buzz  <= 1'b1;
          end else begin
            r_buzz  <= 1'b0;
          end
        end

        StRing: begin
          if (dismiss) begin
            r_state    <= StIdle;
            r_ring_tmr <= '0;
            r_snz_tmr  <= '0;
            r_snz_cnt  <= '0;
            r_buzz     <= 1'b0;
            r_snoozing <= 1'b0;
          end else if (w_ring_end) begin
            if (w_limit) begin
              // Snooze budget used up: the next snooze request ends the event.
              r_state    <= StIdle;
              r_ring_tmr <= '0;
              r_snz_tmr  <= '0;
              r_snz_cnt  <= '0;
              r_buzz     <= 1'b0;
              r_snoozing <= 1'b0;
            end else begin
              r_state    <= StSnooze;
              r_ring_tmr <= '0;
              r_snz_tmr  <= SNZ_LOAD;
              r_snz_cnt  <= r_snz_cnt + 4'd1;
              r_buzz     <= 1'b0;
              r_snoozing <= 1'b1;
            end
          end else begin
            r_ring_tmr <= r_ring_tmr + RW'(1);
          end
        end

        StSnooze: begin
          // Snooze presses are ignored here, so a held button only acts in RING.
          if (dismiss) begin
            r_state    <= StIdle;
            r_ring_tmr <= '0;
            r_snz_tmr  <= '0;
            r_snz_cnt  <= '0;
            r_buzz     <= 1'b0;
            r_snoozing <= 1'b0;
          end else if (w_snz_end) begin
            r_state    <= StRing;
            r_ring_tmr <= '0;
            r_buzz     <= 1'b1;
            r_snoozing <= 1'b0;
          end else begin
            r_snz_tmr  <= r_snz_tmr - SW'(1);
          end
        end

        default: begin
          r_state    <= StIdle;
          r_ring_tmr <= '0;
          r_snz_tmr  <= '0;
          r_snz_cnt  <= '0;
          r_buzz     <= 1'b0;
          r_snoozing <= 1'b0;
        end
      endcase
    end
  end

  assign buzz     = r_buzz;
  assign snoozing = r_snoozing;
  assign snz_cnt  = r_snz_cnt;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
module tb_alarm_snooze_ctrl;

  localparam int SNOOZE_S = 540;
  localparam int RING_S   = 60;
  localparam int MAX_SNZ  = 3;
  localparam int ND       = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] tsec, tmin, thrs, tdays, amin, ahrs, adays;
  logic       alarmon, snooze, dismiss;
  logic       buzz, snoozing;
  logic [3:0] snz_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // Expected {buzz, snoozing, snz_cnt} after each edge.
  logic [5:0] exp_q[$];

  // Reference model: counts buzzing/silent seconds already shown.
  int m_st    = 0;  // 0 idle, 1 ring, 2 snooze
  int m_rung  = 0;
  int m_quiet = 0;
  int m_cnt   = 0;

  alarm_snooze_ctrl #(
    .SNOOZE_S(SNOOZE_S),
    .RING_S  (RING_S),
    .MAX_SNZ (MAX_SNZ),
    .ND      (ND)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .tsec    (tsec),
    .tmin    (tmin),
    .thrs    (thrs),
    .tdays   (tdays),
    .amin    (amin),
    .ahrs    (ahrs),
    .adays   (adays),
    .alarmon (alarmon),
    .snooze  (snooze),
    .dismiss (dismiss),
    .buzz    (buzz),
    .snoozing(snoozing),
    .snz_cnt (snz_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_go_idle();
    m_st = 0; m_rung = 0; m_quiet = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit hit;
    hit = alarmon && (tsec == 0) && (tmin == amin) && (thrs == ahrs) &&
          ((adays == 7'(ND)) || (tdays == adays));
    if (rst || !alarmon) begin
      model_go_idle();
    end else if (m_st == 0) begin
      if (hit) begin m_st = 1; m_rung = 1; end
    end else if (m_st == 1) begin
      if (dismiss) model_go_idle();
      else if (snooze || m_rung == RING_S) begin
        if (m_cnt == MAX_SNZ) model_go_idle();
        else begin m_st = 2; m_cnt++; m_quiet = 1; m_rung = 0; end
      end else m_rung++;
    end else begin
      if (dismiss) model_go_idle();
      else if (m_quiet == SNOOZE_S) begin m_st = 1; m_rung = 1; m_quiet = 0; end
      else m_quiet++;
    end
  endtask

  // One second: model the sampled inputs, push expectation, let the DUT clock, compare.
  task automatic tick();
    logic [5:0] exp_v;
    model_step();
    exp_q.push_back({m_st == 1, m_st == 2, 4'(m_cnt)});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check_val("sb_out", {26'd0, buzz, snoozing, snz_cnt}, {26'd0, exp_v});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until buzz rises; returns the number of silent seconds seen including the first.
  task automatic wait_buzz(output int quiet);
    quiet = 1;
    tick();
    while (!buzz && quiet < SNOOZE_S + 100) begin
      quiet++;
      tick();
    end
    if (!buzz) check_val("wait_buzz_timeout", 32'(buzz), 32'd1);
  endtask

  task automatic set_time(input int d, input int h, input int m, input int s);
    tdays = 7'(d); thrs = 7'(h); tmin = 7'(m); tsec = 7'(s);
  endtask

  task automatic dismiss_now();
    dismiss = 1'b1; tsec = 7'd1;
    tick();
    dismiss = 1'b0;
  endtask

  int quiet;

  initial begin
    rst = 1'b1; alarmon = 1'b1; snooze = 1'b0; dismiss = 1'b0;
    amin = 7'd30; ahrs = 7'd7; adays = 7'd2;
    set_time(0, 0, 0, 0);
    ticks(2);
    check_val("rst_buzz", 32'(buzz), 32'd0);
    check_val("rst_snoozing", 32'(snoozing), 32'd0);
    check_val("rst_cnt", 32'(snz_cnt), 32'd0);
    rst = 1'b0;
    ticks(3);

    // Match -> buzz next cycle, ring timeout after RING_S cycles.
    set_time(2, 7, 30, 0);
    tick();
    check_val("match_buzz", 32'(buzz), 32'd1);
    tsec = 7'd1;
    ticks(RING_S - 1);
    check_val("ring_last_buzz", 32'(buzz), 32'd1);
    tick();
    check_val("timeout_snoozing", 32'(snoozing), 32'd1);
    check_val("timeout_cnt", 32'(snz_cnt), 32'd1);
    check_val("timeout_buzz", 32'(buzz), 32'd0);
    dismiss_now();
    check_val("dismiss_cnt", 32'(snz_cnt), 32'd0);
    check_val("dismiss_snoozing", 32'(snoozing), 32'd0);

    // Snooze at ring cycle 5 -> exactly SNOOZE_S silent cycles.
    tsec = 7'd0;
    tick();
    tsec = 7'd1;
    ticks(4);
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check_val("snz_buzz_off", 32'(buzz), 32'd0);
    wait_buzz(quiet);
    check_val("snz_silent_len", 32'(quiet), 32'(SNOOZE_S));
    dismiss_now();
    check_val("dismiss2_buzz", 32'(buzz), 32'd0);
    check_val("dismiss2_cnt", 32'(snz_cnt), 32'd0);

    // Daily alarm on days 0 and 5; wrong day and nonzero seconds stay silent.
    adays = 7'd7;
    set_time(0, 7, 30, 0);
    tick();
    check_val("daily_d0", 32'(buzz), 32'd1);
    dismiss_now();
    set_time(5, 7, 30, 0);
    tick();
    check_val("daily_d5", 32'(buzz), 32'd1);
    dismiss_now();
    adays = 7'd3;
    set_time(4, 7, 30, 0);
    ticks(2);
    check_val("wrong_day", 32'(buzz), 32'd0);
    adays = 7'd2;
    set_time(2, 7, 30, 1);
    ticks(2);
    check_val("tsec_nonzero", 32'(buzz), 32'd0);

    // Snooze limit: presses 1..3 count, the fourth ends the event.
    tsec = 7'd0;
    tick();
    tsec = 7'd1;
    for (int p = 1; p <= MAX_SNZ + 1; p++) begin
      check_val("limit_ringing", 32'(buzz), 32'd1);
      snooze = 1'b1;
      tick();
      snooze = 1'b0;
      if (p <= MAX_SNZ) begin
        check_val("limit_cnt", 32'(snz_cnt), 32'(p));
        wait_buzz(quiet);
      end else begin
        check_val("limit_end_buzz", 32'(buzz), 32'd0);
        check_val("limit_end_snoozing", 32'(snoozing), 32'd0);
        check_val("limit_end_cnt", 32'(snz_cnt), 32'd0);
      end
    end
    ticks(3);

    // Snooze and dismiss together: dismiss wins.
    tsec = 7'd0;
    tick();
    tsec = 7'd1;
    snooze = 1'b1; dismiss = 1'b1;
    tick();
    check_val("both_snoozing", 32'(snoozing), 32'd0);
    check_val("both_buzz", 32'(buzz), 32'd0);
    snooze = 1'b0; dismiss = 1'b0;
    ticks(3);
    check_val("both_after", 32'(snoozing), 32'd0);

    // alarmon dropped mid-snooze.
    tsec = 7'd0;
    tick();
    tsec = 7'd1;
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    ticks(10);
    check_val("pre_off_snoozing", 32'(snoozing), 32'd1);
    alarmon = 1'b0;
    tick();
    check_val("off_snoozing", 32'(snoozing), 32'd0);
    check_val("off_cnt", 32'(snz_cnt), 32'd0);
    alarmon = 1'b1;

    // rst mid-ring, with a match in the same cycle.
    tsec = 7'd0;
    tick();
    tsec = 7'd1;
    ticks(3);
    rst = 1'b1; tsec = 7'd0;
    tick();
    check_val("rst_ring_buzz", 32'(buzz), 32'd0);
    check_val("rst_ring_snoozing", 32'(snoozing), 32'd0);
    check_val("rst_ring_cnt", 32'(snz_cnt), 32'd0);
    rst = 1'b0; tsec = 7'd1;
    ticks(2);
    check_val("rst_match_ignored", 32'(buzz), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
